// File: rtl/shift_add_mult4.sv
// 4x4 unsigned multiplier built from a sequential shift-and-add engine.
// One operation is accepted outside CALC, takes four CALC steps, and is then presented for one DONE cycle.
module shift_add_mult4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       busy,
  output logic       done,
  output logic [7:0] P
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  mcand;
  logic [7:0]  acc;
  logic [1:0]  cnt;
  logic [7:0]  acc_step;
  logic        accept;
  logic        last;

  // One step: conditionally add the multiplicand to the high half, then shift {carry,hi,lo} right.
  function automatic logic [7:0] add_shift(input logic [7:0] a, input logic [3:0] m);
    logic [4:0] sum;
    sum = a[0] ? ({1'b0, a[7:4]} + {1'b0, m}) : {1'b0, a[7:4]};
    return {sum, a[3:1]};
  endfunction

  always_comb begin
    accept   = (state != CALC) && start;
    last     = (state == CALC) && (cnt == 2'd3);
    acc_step = add_shift(acc, mcand);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = start ? CALC : IDLE;
      CALC:       state_nxt = (cnt == 2'd3) ? DONE : CALC;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= 4'd0;
      acc   <= 8'd0;
      cnt   <= 2'd0;
      P     <= 8'd0;
    end else if (accept) begin
      mcand <= A;
      acc   <= {4'd0, B};
      cnt   <= 2'd0;
    end else if (state == CALC) begin
      acc <= acc_step;
      cnt <= cnt + 2'd1;
      // P only ever sees the finished product, never a partial accumulator.
      if (last) begin
        P <= acc_step;
      end
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule
